// File: rtl/adsr_envelope_if.sv
// adsr_envelope_if: control, sample and status bundle between the note/oscillator
// front end (master) and the ADSR amplitude stage (slave).
interface adsr_envelope_if;
   logic               gate;
   logic [15:0]        attack_rate;
   logic [15:0]        decay_rate;
   logic [7:0]         sustain_level;
   logic [15:0]        release_rate;
   logic signed [7:0]  sample_in;
   logic signed [7:0]  sample_out;
   logic [7:0]         env_level;
   logic [2:0]         state;
   logic               busy;

   modport master (
      output gate, attack_rate, decay_rate, sustain_level, release_rate, sample_in,
      input  sample_out, env_level, state, busy
   );

   modport slave (
      input  gate, attack_rate, decay_rate, sustain_level, release_rate, sample_in,
      output sample_out, env_level, state, busy
   );
endinterface

// File: rtl/adsr_envelope.sv
// adsr_envelope: gate-driven ADSR envelope on a prescaled tick, scaling a signed
// oscillator sample by the 8-bit envelope level with a 2-cycle datapath.
// Optional build macro ADSR_EXP_RELEASE_EN: exponential-like release
// (step = max(1, env*release_rate >> 16)); undefined gives linear release.
module adsr_envelope #(
   parameter int TICK_DIV = 256
) (
   input  logic clk,
   input  logic rst_n,
   adsr_envelope_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ATTACK  = 3'd1,
      DECAY   = 3'd2,
      SUSTAIN = 3'd3,
      RELEASE = 3'd4
   } state_e;

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   state_e             state_q, state_d;
   logic [15:0]        env_q, env_d;
   logic               gate_q;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               tick, rise, fall;
   logic [15:0]        floor_w, rel_step;
   logic [16:0]        att_sum, dec_diff;
   logic signed [16:0] s_ext, e_ext, p_d, p_q;
   logic signed [7:0]  so_q;

   assign tick    = (cnt_q == CW'(TICK_DIV - 1));
   assign cnt_d   = tick ? '0 : cnt_q + 1'b1;
   assign rise    = bus.gate & ~gate_q;
   assign fall    = ~bus.gate & gate_q;
   assign floor_w = {bus.sustain_level, 8'h00};
   assign att_sum = {1'b0, env_q} + {1'b0, bus.attack_rate};
   assign dec_diff = {1'b0, env_q} - {1'b0, bus.decay_rate};

`ifdef ADSR_EXP_RELEASE_EN
   // Step shrinks with the level; never 0 so release always reaches IDLE.
   logic [31:0] rel_prod;
   assign rel_prod = {16'h0000, env_q} * {16'h0000, bus.release_rate};
   assign rel_step = (rel_prod[31:16] == 16'h0000) ? 16'd1 : rel_prod[31:16];
`else
   assign rel_step = bus.release_rate;
`endif

   // Envelope FSM next state: fall beats rise beats the tick update.
   always_comb begin
      state_d = state_q;
      env_d   = env_q;
      case (state_q)
         IDLE: begin
            env_d = 16'h0000;
            if (rise) state_d = ATTACK;
         end
         ATTACK: begin
            if (fall) state_d = RELEASE;
            else if (tick) begin
               if (att_sum[16] || att_sum[15:0] == 16'hFFFF) begin
                  env_d   = 16'hFFFF;
                  state_d = DECAY;
               end else begin
                  env_d = att_sum[15:0];
               end
            end
         end
         DECAY: begin
            if (fall) state_d = RELEASE;
            else if (env_q <= floor_w) begin
               // Sustain raised above the current level: snap up to it.
               env_d   = floor_w;
               state_d = SUSTAIN;
            end else if (tick) begin
               if (dec_diff[16] || dec_diff[15:0] <= floor_w) begin
                  env_d   = floor_w;
                  state_d = SUSTAIN;
               end else begin
                  env_d = dec_diff[15:0];
               end
            end
         end
         SUSTAIN: begin
            if (fall) state_d = RELEASE;
            else      env_d = floor_w;
         end
         RELEASE: begin
            // Retrigger continues from the current level.
            if (rise) state_d = ATTACK;
            else if (tick) begin
               if (env_q <= rel_step) begin
                  env_d   = 16'h0000;
                  state_d = IDLE;
               end else begin
                  env_d = env_q - rel_step;
               end
            end
         end
         default: begin
            state_d = IDLE;
            env_d   = 16'h0000;
         end
      endcase
   end

   // Envelope state, gate edge detector and tick prescaler.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         env_q   <= 16'h0000;
         gate_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         env_q   <= env_d;
         gate_q  <= bus.gate;
         cnt_q   <= cnt_d;
      end
   end

   // Stage 1 multiplies by the level currently on env_level; product fits 16 bits signed.
   assign s_ext = {{9{bus.sample_in[7]}}, bus.sample_in};
   assign e_ext = {9'b0_0000_0000, env_q[15:8]};
   assign p_d   = s_ext * e_ext;

   // Two-stage scaling pipeline: product, then arithmetic >> 8.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q  <= '0;
         so_q <= '0;
      end else begin
         p_q  <= p_d;
         so_q <= p_q[15:8];
      end
   end

   assign bus.sample_out = so_q;
   assign bus.env_level  = env_q[15:8];
   assign bus.state      = state_q;
   assign bus.busy       = (state_q != IDLE);
endmodule
